// File: rtl/memoria_ram_resp.sv
// memoria_ram_resp
// ----------------
// Memory responder for the control unit's rd/we request interface. Holds a
// 2^LARGURA_END x LARGURA_DADO RAM. A rising edge on rd or we (seen while idle)
// starts one access. The access completes after LATENCIA wait cycles and is
// signalled by a one-cycle pronto pulse.
//
// Handshake: the requester raises rd or we with endMem/dataInMem stable. The
// responder accepts on the first rising clock edge that sees the level rise
// while it is idle, and latches address and data at that edge. The requester
// then waits for pronto and samples dataOutMem in the pronto cycle. It must
// drop and re-raise rd/we to issue another request. Edges that arrive while
// busy are dropped, not queued.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   rd, we     in   read / write request levels (rising edge = request)
//   endMem     in   access address, sampled at acceptance
//   dataInMem  in   write data, sampled at acceptance
//   dataOutMem out  last word read (registered)
//   pronto     out  one-cycle completion pulse
//   ocupado    out  request in progress
//   erro       out  sticky flag: rd and we rose in the same cycle
module memoria_ram_resp #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 4,
    parameter int LATENCIA     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rd,
    input  logic                    we,
    input  logic [LARGURA_END-1:0]  endMem,
    input  logic [LARGURA_DADO-1:0] dataInMem,
    output logic [LARGURA_DADO-1:0] dataOutMem,
    output logic                    pronto,
    output logic                    ocupado,
    output logic                    erro
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ESPERA  = 2'd1;
    localparam logic [1:0] CONCLUI = 2'd2;

    localparam int         PROF    = 1 << LARGURA_END;
    localparam logic [3:0] CNT_FIM = 4'(LATENCIA - 1);

    logic [1:0]              estado_q, estado_d;
    logic [3:0]              cont_q, cont_d;
    logic                    rd_ant_q, we_ant_q;
    logic                    op_esc_q, op_esc_d;
    logic [LARGURA_END-1:0]  end_q, end_d;
    logic [LARGURA_DADO-1:0] dado_q, dado_d;
    logic [LARGURA_DADO-1:0] dout_q, dout_d;
    logic                    pronto_q, pronto_d;
    logic                    ocupado_q, ocupado_d;
    logic                    erro_q, erro_d;
    logic                    mem_we;
    logic                    borda_rd, borda_we;

    logic [LARGURA_DADO-1:0] mem [PROF];

    // The previous-level flops always track their inputs, so a level still
    // high when the FSM returns to idle does not count as a new request.
    assign borda_rd = rd & ~rd_ant_q;
    assign borda_we = we & ~we_ant_q;

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        op_esc_d  = op_esc_q;
        end_d     = end_q;
        dado_d    = dado_q;
        dout_d    = dout_q;
        pronto_d  = 1'b0;
        ocupado_d = ocupado_q;
        erro_d    = erro_q;
        mem_we    = 1'b0;

        // ocupado falls in the cycle after the pronto pulse. A request
        // accepted in that same cycle sets it again below.
        if (pronto_q) begin
            ocupado_d = 1'b0;
        end

        case (estado_q)
            OCIOSO: begin
                if (borda_rd && borda_we) begin
                    erro_d = 1'b1;
                end else if (borda_rd || borda_we) begin
                    op_esc_d  = borda_we;
                    end_d     = endMem;
                    dado_d    = dataInMem;
                    cont_d    = 4'd0;
                    estado_d  = ESPERA;
                    ocupado_d = 1'b1;
                    erro_d    = 1'b0;
                end
            end
            ESPERA: begin
                cont_d = cont_q + 4'd1;
                if (cont_q == CNT_FIM) begin
                    estado_d = CONCLUI;
                end
            end
            CONCLUI: begin
                // pronto and dataOutMem are registered at the edge that
                // leaves CONCLUI, so both appear in the same cycle.
                pronto_d = 1'b1;
                estado_d = OCIOSO;
                if (op_esc_q) begin
                    mem_we = 1'b1;
                end else begin
                    dout_d = mem[end_q];
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            cont_q    <= 4'd0;
            rd_ant_q  <= 1'b0;
            we_ant_q  <= 1'b0;
            op_esc_q  <= 1'b0;
            end_q     <= '0;
            dado_q    <= '0;
            dout_q    <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            rd_ant_q  <= rd;
            we_ant_q  <= we;
            op_esc_q  <= op_esc_d;
            end_q     <= end_d;
            dado_q    <= dado_d;
            dout_q    <= dout_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
            erro_q    <= erro_d;
        end
    end

    // RAM contents survive reset. Reset blocks the commit so that an aborted
    // write never lands.
    always_ff @(posedge clock) begin
        if (mem_we && reset) begin
            mem[end_q] <= dado_q;
        end
    end

    assign dataOutMem = dout_q;
    assign pronto     = pronto_q;
    assign ocupado    = ocupado_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_memoria_ram_resp.sv
// Testbench for memoria_ram_resp (default parameters, LATENCIA=2).
module tb_memoria_ram_resp;

    logic       clock;
    logic       reset;
    logic       rd;
    logic       we;
    logic [3:0] endMem;
    logic [7:0] dataInMem;
    logic [7:0] dataOutMem;
    logic       pronto;
    logic       ocupado;
    logic       erro;

    memoria_ram_resp dut (
        .clock      (clock),
        .reset      (reset),
        .rd         (rd),
        .we         (we),
        .endMem     (endMem),
        .dataInMem  (dataInMem),
        .dataOutMem (dataOutMem),
        .pronto     (pronto),
        .ocupado    (ocupado),
        .erro       (erro)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] model_mem [16];
    logic [7:0] last_rd;
    int n_cmp;
    int n_err;

    typedef struct {
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One complete request: raise the level, wait (bounded) for pronto,
    // check latency and data, drop the level, check the idle cycle after.
    task automatic do_req(input bit wr, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd);
        int  n;
        bit  seen;
        logic [7:0] e;
        endMem    = a;
        dataInMem = d;
        if (wr) we = 1'b1;
        else begin
            rd = 1'b1;
            exp_q.push_back(exp_rd);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            step();
            n++;
            if (n == 1) begin
                chk("ocupado_apos_aceite", ocupado, 1);
                chk("erro_limpo_apos_aceite", erro, 0);
            end
            if (pronto) seen = 1'b1;
        end
        chk("pronto_visto", seen, 1);
        if (seen) begin
            chk("latencia_pronto", n, 4);
            chk("ocupado_com_pronto", ocupado, 1);
            if (wr) begin
                model_mem[a] = d;
                chk("dout_inalterado_escrita", dataOutMem, last_rd);
            end else begin
                e = exp_q.pop_front();
                chk("dout_leitura", dataOutMem, e);
                last_rd = e;
            end
        end else if (!wr) begin
            void'(exp_q.pop_front());
        end
        rd = 1'b0;
        we = 1'b0;
        step();
        chk("pronto_um_ciclo", pronto, 0);
        chk("ocupado_cai", ocupado, 0);
    endtask

    initial begin
        int         np;
        logic [3:0] ra;
        logic [7:0] rdat;

        n_cmp     = 0;
        n_err     = 0;
        last_rd   = 8'h00;
        reset     = 1'b0;
        rd        = 1'b0;
        we        = 1'b0;
        endMem    = 4'd0;
        dataInMem = 8'd0;

        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 8'h00};
        vecs[1]  = '{1'b0, 4'd3,  8'h00, 8'hA5};
        vecs[2]  = '{1'b1, 4'd0,  8'h5A, 8'h00};
        vecs[3]  = '{1'b1, 4'd15, 8'hFF, 8'h00};
        vecs[4]  = '{1'b0, 4'd0,  8'h00, 8'h5A};
        vecs[5]  = '{1'b0, 4'd15, 8'h00, 8'hFF};
        vecs[6]  = '{1'b1, 4'd7,  8'h42, 8'h00};
        vecs[7]  = '{1'b1, 4'd4,  8'h3C, 8'h00};
        vecs[8]  = '{1'b1, 4'd2,  8'hC3, 8'h00};
        vecs[9]  = '{1'b0, 4'd7,  8'h00, 8'h42};
        vecs[10] = '{1'b0, 4'd4,  8'h00, 8'h3C};
        vecs[11] = '{1'b0, 4'd3,  8'h00, 8'hA5};

        // ---------------- reset ----------------
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("reset_dout", dataOutMem, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_erro", erro, 0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
        end

        // ---------------- conflict: rd and we rise together ----------------
        endMem    = 4'd7;
        dataInMem = 8'h99;
        rd        = 1'b1;
        we        = 1'b1;
        step();
        chk("conflito_erro", erro, 1);
        chk("conflito_ocupado", ocupado, 0);
        np = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pronto) np++;
            if (ocupado) np++;
        end
        chk("conflito_sem_pronto", np, 0);
        rd = 1'b0;
        we = 1'b0;
        step();
        chk("conflito_erro_retido", erro, 1);
        do_req(1'b0, 4'd7, 8'h00, 8'h42);
        chk("conflito_erro_limpo", erro, 0);

        // ---------------- busy discard ----------------
        endMem = 4'd2;
        rd     = 1'b1;
        step();
        exp_q.push_back(8'hC3);
        we        = 1'b1;
        dataInMem = 8'h11;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pronto) begin
                np++;
                chk("descarte_dout", dataOutMem, exp_q.pop_front());
                last_rd = 8'hC3;
            end
        end
        chk("descarte_um_pronto", np, 1);
        rd = 1'b0;
        we = 1'b0;
        step();
        do_req(1'b0, 4'd2, 8'h00, 8'hC3);

        // ---------------- held level ----------------
        endMem = 4'd0;
        rd     = 1'b1;
        exp_q.push_back(8'h5A);
        np = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pronto) begin
                np++;
                chk("nivel_dout", dataOutMem, exp_q.pop_front());
                last_rd = 8'h5A;
            end
        end
        chk("nivel_um_pronto", np, 1);
        rd = 1'b0;
        step();

        // ---------------- reset mid-write ----------------
        endMem    = 4'd4;
        dataInMem = 8'h77;
        we        = 1'b1;
        step();
        chk("reset_meio_ocupado", ocupado, 1);
        step();
        reset = 1'b0;
        we    = 1'b0;
        step();
        chk("reset_meio_dout", dataOutMem, 0);
        chk("reset_meio_pronto", pronto, 0);
        chk("reset_meio_ocupado0", ocupado, 0);
        chk("reset_meio_erro", erro, 0);
        reset   = 1'b1;
        last_rd = 8'h00;
        np = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (pronto) np++;
        end
        chk("reset_meio_sem_pronto", np, 0);
        do_req(1'b0, 4'd4, 8'h00, 8'h3C);

        // ---------------- random write / read-back ----------------
        for (int i = 0; i < 4; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rdat = 8'($urandom_range(0, 255));
            do_req(1'b1, ra, rdat, 8'h00);
            do_req(1'b0, ra, 8'h00, model_mem[ra]);
        end

        chk("fila_vazia", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
